// File: rtl/runner_motion.sv
`default_nettype none
// ============================================================================
// Module   : runner_motion
// Purpose  : Multi-player runner motion controller. Each player owns an
//            independent channel with a run/jump/duck/crash state machine,
//            integer jump physics (gravity, early-release jump cut, airborne
//            speed drop, ceiling clamp) and a run-cycle animation counter.
//            Motion advances only on the frame `update` strobe; crash and
//            restart act on any cycle. All outputs are registered.
// Ports    : clk      - system clock
//            rst      - asynchronous reset, active-high
//            update   - one-cycle frame strobe
//            jumping  - [PLAYERS] jump button level
//            ducking  - [PLAYERS] duck button level
//            crash    - [PLAYERS] collision pulse
//            restart  - global game restart pulse
//            state    - [PLAYERS*2] 0=RUN 1=JUMP 2=DUCK 3=CRASH, player i at [2i+:2]
//            y        - [PLAYERS*POS_W] vertical position, player i at [POS_W*i+:POS_W]
//            frame    - [PLAYERS] animation frame select
// Revision : 1.0 - initial release
// ============================================================================
module runner_motion #(
    parameter int PLAYERS         = 2,
    parameter int POS_W           = 11,
    parameter int VEL_W           = 8,
    parameter int GROUND_Y        = 93,
    parameter int JUMP_VEL        = 10,
    parameter int GRAVITY         = 1,
    parameter int MIN_JUMP_HEIGHT = 30,
    parameter int CUT_VEL         = 3,
    parameter int DROP_VEL        = 5,
    parameter int ANIM_DIV        = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       update,
    input  logic [PLAYERS-1:0]         jumping,
    input  logic [PLAYERS-1:0]         ducking,
    input  logic [PLAYERS-1:0]         crash,
    input  logic                       restart,
    output logic [2*PLAYERS-1:0]       state,
    output logic [POS_W*PLAYERS-1:0]   y,
    output logic [PLAYERS-1:0]         frame
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JUMP  = 2'd1,
        ST_DUCK  = 2'd2,
        ST_CRASH = 2'd3
    } state_t;

    // Physics is evaluated two bits wider than the position so that both the
    // overshoot past the ground and a negative (above-screen) result are
    // representable as signed values.
    localparam int CALC_W = POS_W + 2;
    localparam int CNT_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic signed [CALC_W-1:0] c_ground    = CALC_W'(GROUND_Y);
    localparam logic signed [CALC_W-1:0] c_min_h     = CALC_W'(MIN_JUMP_HEIGHT);
    localparam logic signed [CALC_W-1:0] c_cut       = CALC_W'(CUT_VEL);
    localparam logic signed [CALC_W-1:0] c_drop_neg  = CALC_W'(-DROP_VEL);
    localparam logic signed [CALC_W-1:0] c_grav      = CALC_W'(GRAVITY);
    localparam logic signed [CALC_W-1:0] c_vel_max   = CALC_W'((1 << (VEL_W - 1)) - 1);
    localparam logic signed [CALC_W-1:0] c_vel_min   = CALC_W'(-(1 << (VEL_W - 1)));
    localparam logic        [POS_W-1:0]  c_ground_y  = POS_W'(GROUND_Y);
    localparam logic signed [VEL_W-1:0]  c_jump_vel  = VEL_W'(JUMP_VEL);
    localparam logic        [CNT_W-1:0]  c_cnt_last  = CNT_W'(ANIM_DIV - 1);

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_ch
            state_t                    r_state, w_state_n;
            logic [POS_W-1:0]          r_y, w_y_n;
            logic signed [VEL_W-1:0]   r_vel, w_vel_n;
            logic [CNT_W-1:0]          r_cnt, w_cnt_n;
            logic                      r_frame, w_frame_n;

            logic signed [CALC_W-1:0]  w_y_ext, w_vel_ext, w_height;
            logic signed [CALC_W-1:0]  w_vel_e, w_y_calc, w_vel_calc;
            logic signed [VEL_W-1:0]   w_vel_sat;

            // Jump physics for this channel, evaluated every cycle and used
            // only when an update arrives in the JUMP state.
            always_comb begin
                w_y_ext   = {2'b00, r_y};
                w_vel_ext = {{(CALC_W-VEL_W){r_vel[VEL_W-1]}}, r_vel};
                w_height  = c_ground - w_y_ext;

                // Speed drop beats jump cut; the cut only applies once the
                // runner has climbed high enough and is still rising fast.
                if (ducking[gi]) begin
                    w_vel_e = (w_vel_ext < c_drop_neg) ? w_vel_ext : c_drop_neg;
                end else if (!jumping[gi] && (w_vel_ext > c_cut) && (w_height >= c_min_h)) begin
                    w_vel_e = c_cut;
                end else begin
                    w_vel_e = w_vel_ext;
                end

                w_y_calc   = w_y_ext - w_vel_e;
                w_vel_calc = w_vel_e - c_grav;

                if (w_vel_calc > c_vel_max) begin
                    w_vel_sat = c_vel_max[VEL_W-1:0];
                end else if (w_vel_calc < c_vel_min) begin
                    w_vel_sat = c_vel_min[VEL_W-1:0];
                end else begin
                    w_vel_sat = w_vel_calc[VEL_W-1:0];
                end
            end

            // Next-state and datapath update; everything holds by default.
            always_comb begin
                w_state_n = r_state;
                w_y_n     = r_y;
                w_vel_n   = r_vel;
                w_cnt_n   = r_cnt;
                w_frame_n = r_frame;

                if (crash[gi]) begin
                    // Crash freezes the datapath and outranks restart/update.
                    w_state_n = ST_CRASH;
                end else begin
                    case (r_state)
                        ST_CRASH: begin
                            if (restart) begin
                                w_state_n = ST_RUN;
                                w_y_n     = c_ground_y;
                                w_vel_n   = '0;
                                w_cnt_n   = '0;
                                w_frame_n = 1'b0;
                            end
                        end
                        ST_RUN, ST_DUCK: begin
                            if (update) begin
                                if (r_cnt == c_cnt_last) begin
                                    w_cnt_n   = '0;
                                    w_frame_n = ~r_frame;
                                end else begin
                                    w_cnt_n = r_cnt + CNT_W'(1);
                                end
                                if (jumping[gi]) begin
                                    // Takeoff: velocity loaded, y moves next update.
                                    w_state_n = ST_JUMP;
                                    w_vel_n   = c_jump_vel;
                                end else begin
                                    w_state_n = ducking[gi] ? ST_DUCK : ST_RUN;
                                end
                            end
                        end
                        ST_JUMP: begin
                            if (update) begin
                                if (w_y_calc >= c_ground) begin
                                    w_state_n = ducking[gi] ? ST_DUCK : ST_RUN;
                                    w_y_n     = c_ground_y;
                                    w_vel_n   = '0;
                                end else if (w_y_calc[CALC_W-1]) begin
                                    // Hit the top of the screen: stop and let gravity take over.
                                    w_y_n   = '0;
                                    w_vel_n = '0;
                                end else begin
                                    w_y_n   = w_y_calc[POS_W-1:0];
                                    w_vel_n = w_vel_sat;
                                end
                            end
                        end
                        default: begin
                            w_state_n = r_state;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_RUN;
                    r_y     <= c_ground_y;
                    r_vel   <= '0;
                    r_cnt   <= '0;
                    r_frame <= 1'b0;
                end else begin
                    r_state <= w_state_n;
                    r_y     <= w_y_n;
                    r_vel   <= w_vel_n;
                    r_cnt   <= w_cnt_n;
                    r_frame <= w_frame_n;
                end
            end

            assign state[2*gi +: 2]        = r_state;
            assign y[POS_W*gi +: POS_W]    = r_y;
            assign frame[gi]               = r_frame;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_runner_motion.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_runner_motion
// Purpose  : Self-checking bench for runner_motion (2 players). Directed
//            stimulus pushes hand-computed expectations into a scoreboard
//            queue; a monitor pops and compares one cycle after each checked
//            step, and an event-driven monitor handles the asynchronous
//            reset check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_runner_motion;

    localparam int PW = 11;
    localparam logic [1:0] c_run   = 2'd0;
    localparam logic [1:0] c_jump  = 2'd1;
    localparam logic [1:0] c_duck  = 2'd2;
    localparam logic [1:0] c_crash = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          update;
    logic [1:0]    jumping;
    logic [1:0]    ducking;
    logic [1:0]    crash;
    logic          restart;
    logic [3:0]    state;
    logic [2*PW-1:0] y;
    logic [1:0]    frame;

    runner_motion dut (
        .clk     (clk),
        .rst     (rst),
        .update  (update),
        .jumping (jumping),
        .ducking (ducking),
        .crash   (crash),
        .restart (restart),
        .state   (state),
        .y       (y),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [2*PW-1:0] yy;
        logic [1:0]  fr;
        logic [1:0]  fm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic chk   = 1'b0;
    logic chk_d = 1'b0;
    event async_ev;

    task automatic check_one();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: output presented with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (state !== e.st || y !== e.yy || ((frame & e.fm) !== (e.fr & e.fm))) begin
                bad++;
                $display("FAIL %s: got state=%b y1=%0d y0=%0d frame=%b, want state=%b y1=%0d y0=%0d frame=%b (mask %b)",
                         e.name, state, y[2*PW-1:PW], y[PW-1:0], frame,
                         e.st, e.yy[2*PW-1:PW], e.yy[PW-1:0], e.fr, e.fm);
            end
        end
    endtask

    // Synchronous monitor: compares one cycle after a checked step.
    always @(posedge clk) chk_d <= chk;
    always @(negedge clk) if (chk_d) check_one();
    // Asynchronous monitor: compares mid-cycle when triggered.
    always @(async_ev) check_one();

    task automatic push_exp(input string nm, input logic [1:0] s0, input logic [1:0] s1,
                            input int y0, input int y1, input logic [1:0] fr, input logic [1:0] fm);
        exp_t e;
        e.name = nm;
        e.st   = {s1, s0};
        e.yy   = {PW'(y1), PW'(y0)};
        e.fr   = fr;
        e.fm   = fm;
        sb.push_back(e);
    endtask

    task automatic expect_out(input string nm, input logic [1:0] s0, input logic [1:0] s1,
                              input int y0, input int y1, input logic [1:0] fr, input logic [1:0] fm);
        push_exp(nm, s0, s1, y0, y1, fr, fm);
        chk = 1'b1;
    endtask

    task automatic drive(input logic upd, input logic [1:0] jmp, input logic [1:0] dck,
                         input logic [1:0] crs, input logic rs);
        @(negedge clk);
        update  = upd;
        jumping = jmp;
        ducking = dck;
        crash   = crs;
        restart = rs;
        chk     = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int jy[21] = '{83, 74, 66, 59, 53, 48, 44, 41, 39, 38, 38, 39, 41, 44, 48, 53, 59, 66, 74, 83, 93};
        int er[17] = '{83, 74, 66, 59, 56, 54, 53, 53, 54, 56, 59, 63, 68, 74, 81, 89, 93};
        int p1[6]  = '{83, 74, 66, 59, 53, 48};
        logic f;

        rst = 1'b1; update = 1'b0; jumping = '0; ducking = '0; crash = '0; restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        drive(0, 2'b00, 2'b00, 2'b00, 0);
        expect_out("reset", c_run, c_run, 93, 93, 2'b00, 2'b11);

        // Full jump on player 0, jump held throughout
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        expect_out("full_takeoff", c_jump, c_run, 93, 93, 2'b00, 2'b00);
        for (int k = 0; k < 21; k++) begin
            drive(1, 2'b01, 2'b00, 2'b00, 0);
            expect_out($sformatf("full_jump_%0d", k + 1), (k == 20) ? c_run : c_jump, c_run,
                       jy[k], 93, 2'b00, 2'b00);
        end
        drive(1, 2'b00, 2'b00, 2'b00, 0);
        expect_out("full_after_land", c_run, c_run, 93, 93, 2'b00, 2'b00);

        // Early release after 4 physics updates
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        expect_out("early_takeoff", c_jump, c_run, 93, 93, 2'b00, 2'b00);
        for (int k = 0; k < 17; k++) begin
            drive(1, (k < 4) ? 2'b01 : 2'b00, 2'b00, 2'b00, 0);
            expect_out($sformatf("early_%0d", k + 1), (k == 16) ? c_run : c_jump, c_run,
                       er[k], 93, 2'b00, 2'b00);
        end

        // Speed drop from y=74 (vel=8)
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        expect_out("drop_at_74", c_jump, c_run, 74, 93, 2'b00, 2'b00);
        drive(0, 2'b01, 2'b00, 2'b00, 0);
        expect_out("no_update_hold", c_jump, c_run, 74, 93, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b01, 2'b00, 0);
        expect_out("drop_first", c_jump, c_run, 79, 93, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b01, 2'b00, 0);
        drive(1, 2'b00, 2'b01, 2'b00, 0);
        drive(1, 2'b00, 2'b01, 2'b00, 0);
        expect_out("drop_land_duck", c_duck, c_run, 93, 93, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b01, 2'b00, 0);
        expect_out("duck_stay", c_duck, c_run, 93, 93, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00, 2'b00, 0);
        expect_out("duck_release", c_run, c_run, 93, 93, 2'b00, 2'b00);

        // Asynchronous reset mid-jump, after 5 updates
        for (int k = 0; k < 5; k++) drive(1, 2'b01, 2'b00, 2'b00, 0);
        drive(0, 2'b00, 2'b00, 2'b00, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        push_exp("async_reset", c_run, c_run, 93, 93, 2'b00, 2'b11);
        ->async_ev;
        @(negedge clk);
        rst = 1'b0;

        // Animation cadence in RUN then DUCK
        for (int k = 1; k <= 12; k++) begin
            drive(1, 2'b00, 2'b00, 2'b00, 0);
            f = (k >= 6 && k < 12);
            expect_out($sformatf("anim_run_%0d", k), c_run, c_run, 93, 93, {f, f}, 2'b11);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(1, 2'b00, 2'b11, 2'b00, 0);
            f = (k >= 6 && k < 12);
            expect_out($sformatf("anim_duck_%0d", k), c_duck, c_duck, 93, 93, {f, f}, 2'b11);
        end

        // Crash / restart on player 1
        drive(1, 2'b10, 2'b00, 2'b00, 0);
        expect_out("p1_takeoff", c_run, c_jump, 93, 93, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) begin
            drive(1, 2'b10, 2'b00, 2'b00, 0);
            expect_out($sformatf("p1_rise_%0d", k + 1), c_run, c_jump, 93, p1[k], 2'b00, 2'b00);
        end
        drive(0, 2'b00, 2'b00, 2'b10, 0);
        expect_out("p1_crash", c_run, c_crash, 93, 48, 2'b00, 2'b00);
        drive(1, 2'b10, 2'b00, 2'b00, 0);
        expect_out("p1_frozen", c_run, c_crash, 93, 48, 2'b00, 2'b00);
        drive(1, 2'b01, 2'b00, 2'b00, 0);
        expect_out("p0_jump_during_crash", c_jump, c_crash, 93, 48, 2'b00, 2'b00);
        drive(0, 2'b00, 2'b00, 2'b10, 1);
        expect_out("crash_beats_restart", c_jump, c_crash, 93, 48, 2'b00, 2'b00);
        drive(0, 2'b00, 2'b00, 2'b00, 1);
        expect_out("restart", c_jump, c_run, 93, 93, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00, 2'b00, 0);
        expect_out("after_restart", c_jump, c_run, 83, 93, 2'b00, 2'b00);

        drive(0, 2'b00, 2'b00, 2'b00, 0);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d unconsumed expectations, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
